ctrl_pipe: RTL and testbench
============================

# ctrl_pipe

Carries the ID-stage control bundles (`wb`, `mem`, `ex`) down the pipeline through the ID/EX, EX/MEM and MEM/WB control registers. At each stage it decodes the bundle into the individual strobes that stage consumes. It applies hazard bubbles, branch flushes and whole-pipe freezes to the control path. It sits between the ID-stage control decoder and the EX/MEM/WB datapath, as the consumer end of the bundle interface.

## Interface
- `CNT_W`, default 32: width of the statistics counters (only present with stats enabled).
- `clk` input 1: pipeline clock, rising edge.
- `rst` input 1: synchronous reset, active-low.
- `id_valid` input 1: ID stage holds a real instruction.
- `id_wb` input 2: {RegWrite, MemToReg}.
- `id_mem` input 3: {Branch, MemRead, MemWrite}.
- `id_ex` input 4: {RegDst, ALUOp[1:0], ALUSrc}.
- `hazard_stall` input 1: load-use stall; a bubble is loaded into ID/EX.
- `flush` input 1: taken branch; ID/EX and EX/MEM are loaded with bubbles.
- `freeze` input 1: all three stage registers hold.
- `ex_reg_dst`, `ex_alu_src` output 1 each; `ex_alu_op` output 2.
- `mem_branch`, `mem_read`, `mem_write` output 1 each.
- `wb_reg_write`, `wb_mem_to_reg` output 1 each.
- `ex_valid`, `mem_valid`, `wb_valid` output 1 each: the stage holds a real instruction.
- `bubble_cnt`, `retire_cnt` output `CNT_W` each: present only with `CTRL_PIPE_STATS_EN`.

## Operation
- **Stage contents.**
  - ID/EX holds {valid, wb, mem, ex} (10 bits).
  - EX/MEM holds {valid, wb, mem} (6 bits).
  - MEM/WB holds {valid, wb} (3 bits).
- **Outputs.** All outputs are direct decodes of the stage registers. A stage whose valid bit is 0 drives all of its strobes to 0, regardless of stored bits.
- **Bubble.** A bubble is the all-zero value, including valid=0.
- **Per-edge priority.**
  1. `rst`=0: all registers and counters are cleared.
  2. `freeze`=1: all registers hold. `flush` and `hazard_stall` are ignored; upstream keeps them asserted until freeze drops.
  3. `flush`=1: ID/EX gets a bubble. EX/MEM gets a bubble. MEM/WB loads from EX/MEM normally, so the branch in MEM retires.
  4. `hazard_stall`=1: ID/EX gets a bubble. EX/MEM and MEM/WB advance.
  5. Otherwise: ID/EX loads {id_valid, id_wb, id_mem, id_ex}, and the other stages advance.
- **id_valid=0.** This loads a bubble into ID/EX even though the bundle bits are present.
- **No combinational input-to-output path.** Every output is registered.

## Timing
- Reset values: every output is 0, and the counters are 0.
- Latency:
  - ID bundle to EX strobes: 1 cycle.
  - ID bundle to MEM strobes: 2 cycles.
  - ID bundle to WB strobes: 3 cycles.
- Each freeze cycle adds exactly 1 cycle of latency to every in-flight instruction.
- Flush and hazard_stall asserted together: flush wins. A single edge produces two bubbles (ID/EX and EX/MEM), not three.
- Reset is honoured mid-stream, including during freeze. All in-flight control is discarded and no retire is counted on that edge.
- Throughput: one instruction per cycle when there is no stall, flush or freeze.

## Configuration
- `CTRL_PIPE_STATS_EN` defined:
  - `bubble_cnt` increments by 1 on each non-freeze edge on which a bubble is loaded into ID/EX by `hazard_stall` or `flush`.
  - `retire_cnt` increments by 1 on each non-freeze edge on which MEM/WB is valid.
  - Both counters wrap modulo 2^CNT_W.
- `CTRL_PIPE_STATS_EN` undefined:
  - The counter ports and logic are absent.
  - All other behaviour is identical.

## Structure
- Shared package `ctrl_pkg` contains:
  - Opcode constants: R=000000, LW=100011, SW=101011, BEQ=000100.
  - Bundle widths (WB_W=2, MEM_W=3, EX_W=4).
  - Bit-position constants for each field.
  - Packed typedefs for the three bundles.
- Sub-module `ctrl_stage_reg`, instantiated three times:
  - Parameterised by width.
  - Inputs: `d`, `hold`, `bubble`.
  - Provides the synchronous active-low reset.

## Test plan
- **Reset.** Drive `rst`=0 for 2 cycles with `id_valid`=1 and an R bundle (ex=1100, mem=000, wb=10) → all outputs 0. After release: `ex_reg_dst`=1 and `ex_alu_op`=10 one cycle later; `wb_reg_write`=1 three cycles later.
- **LW then SW back-to-back.** LW bundle (0001/010/11) followed by SW bundle (0001/001/00) → `mem_read`=1 at cycle 2 and `mem_write`=1 at cycle 3. `wb_mem_to_reg`=1 only at cycle 3. Unused strobes stay 0 throughout.
- **Hazard stall.** LW enters, then `hazard_stall`=1 for one cycle with an R bundle on ID → EX strobes are 0 and `ex_valid`=0 for that cycle. The LW still reaches WB at cycle 3. `bubble_cnt`=1 (stats build).
- **Flush.** BEQ (0010/100/00) in MEM while `flush`=1 → `mem_branch`=1 that cycle. Next cycle, `ex_valid`=0 and `mem_valid`=0, and `wb_valid`=1 for the BEQ. `bubble_cnt` increments by 1.
- **Freeze with simultaneous flush and stall.** `freeze`=1 for 3 cycles with `flush`=1 and `hazard_stall`=1 → all outputs are unchanged and the counters are unchanged. On release with `flush` still high: two bubbles are inserted and `bubble_cnt` increments by exactly 1.
- **Counter wrap.** With `CNT_W`=4, run 17 valid instructions → `retire_cnt` reads 1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control-bundle definitions for the ID-stage decoder and ctrl_pipe.
package ctrl_pkg;

  localparam int unsigned WB_W  = 2;
  localparam int unsigned MEM_W = 3;
  localparam int unsigned EX_W  = 4;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  localparam int unsigned WB_REG_WRITE_B  = 1;
  localparam int unsigned WB_MEM_TO_REG_B = 0;
  localparam int unsigned MEM_BRANCH_B    = 2;
  localparam int unsigned MEM_READ_B      = 1;
  localparam int unsigned MEM_WRITE_B     = 0;
  localparam int unsigned EX_REG_DST_B    = 3;
  localparam int unsigned EX_ALU_OP_HI_B  = 2;
  localparam int unsigned EX_ALU_OP_LO_B  = 1;
  localparam int unsigned EX_ALU_SRC_B    = 0;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    logic branch;
    logic read;
    logic write;
  } mem_ctrl_t;

  typedef struct packed {
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
  } ex_ctrl_t;

  typedef struct packed {
    wb_ctrl_t  wb;
    mem_ctrl_t mem;
    ex_ctrl_t  ex;
  } id_ctrl_t;

  typedef struct packed {
    logic      valid;
    wb_ctrl_t  wb;
    mem_ctrl_t mem;
    ex_ctrl_t  ex;
  } idex_t;

  typedef struct packed {
    logic      valid;
    wb_ctrl_t  wb;
    mem_ctrl_t mem;
  } exmem_t;

  typedef struct packed {
    logic     valid;
    wb_ctrl_t wb;
  } memwb_t;

  // Reference opcode-to-bundle decode used by the upstream ID stage.
  function automatic id_ctrl_t ctrl_decode(input logic [5:0] opcode);
    id_ctrl_t c;
    c = '0;
    case (opcode)
      OP_R: begin
        c.wb.reg_write = 1'b1;
        c.ex.reg_dst   = 1'b1;
        c.ex.alu_op    = 2'b10;
      end
      OP_LW: begin
        c.wb.reg_write  = 1'b1;
        c.wb.mem_to_reg = 1'b1;
        c.mem.read      = 1'b1;
        c.ex.alu_src    = 1'b1;
      end
      OP_SW: begin
        c.mem.write  = 1'b1;
        c.ex.alu_src = 1'b1;
      end
      OP_BEQ: begin
        c.mem.branch = 1'b1;
        c.ex.alu_op  = 2'b01;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline control register: hold beats bubble, bubble loads all-zero.
module ctrl_stage_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  input  logic         hold,
  input  logic         bubble,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (!hold) begin
      q <= bubble ? '0 : d;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-path pipeline ID/EX -> EX/MEM -> MEM/WB with bubble, flush and freeze.
// Optional statistics counters are built when CTRL_PIPE_STATS_EN is defined.
module ctrl_pipe
  import ctrl_pkg::*;
`ifdef CTRL_PIPE_STATS_EN
#(
  parameter int unsigned CNT_W = 32
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [WB_W-1:0]  id_wb,
  input  logic [MEM_W-1:0] id_mem,
  input  logic [EX_W-1:0]  id_ex,
  input  logic             hazard_stall,
  input  logic             flush,
  input  logic             freeze,
  output logic             ex_reg_dst,
  output logic             ex_alu_src,
  output logic [1:0]       ex_alu_op,
  output logic             mem_branch,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_reg_write,
  output logic             wb_mem_to_reg,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid
`ifdef CTRL_PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] retire_cnt
`endif
);

  idex_t  idex_d, idex_q;
  exmem_t exmem_d, exmem_q;
  memwb_t memwb_d, memwb_q;

  logic [EX_W-1:0]  ex_bits;
  logic [MEM_W-1:0] mem_bits;
  logic [WB_W-1:0]  wb_bits;

  // Next-stage payloads; an invalid ID slot becomes a bubble.
  always_comb begin
    idex_d  = '{valid: id_valid, wb: wb_ctrl_t'(id_wb), mem: mem_ctrl_t'(id_mem),
                ex: ex_ctrl_t'(id_ex)};
    exmem_d = '{valid: idex_q.valid, wb: idex_q.wb, mem: idex_q.mem};
    memwb_d = '{valid: exmem_q.valid, wb: exmem_q.wb};
  end

  ctrl_stage_reg #(.W($bits(idex_t))) u_idex (
    .clk    (clk),
    .rst    (rst),
    .d      (idex_d),
    .hold   (freeze),
    .bubble (flush | hazard_stall | ~id_valid),
    .q      (idex_q)
  );

  ctrl_stage_reg #(.W($bits(exmem_t))) u_exmem (
    .clk    (clk),
    .rst    (rst),
    .d      (exmem_d),
    .hold   (freeze),
    .bubble (flush),
    .q      (exmem_q)
  );

  ctrl_stage_reg #(.W($bits(memwb_t))) u_memwb (
    .clk    (clk),
    .rst    (rst),
    .d      (memwb_d),
    .hold   (freeze),
    .bubble (1'b0),
    .q      (memwb_q)
  );

  // Strobe decode straight off the stage registers, gated by each stage's valid.
  always_comb begin
    ex_bits  = idex_q.ex;
    mem_bits = exmem_q.mem;
    wb_bits  = memwb_q.wb;

    ex_valid      = idex_q.valid;
    ex_reg_dst    = idex_q.valid & ex_bits[EX_REG_DST_B];
    ex_alu_op     = {2{idex_q.valid}} & ex_bits[EX_ALU_OP_HI_B:EX_ALU_OP_LO_B];
    ex_alu_src    = idex_q.valid & ex_bits[EX_ALU_SRC_B];

    mem_valid     = exmem_q.valid;
    mem_branch    = exmem_q.valid & mem_bits[MEM_BRANCH_B];
    mem_read      = exmem_q.valid & mem_bits[MEM_READ_B];
    mem_write     = exmem_q.valid & mem_bits[MEM_WRITE_B];

    wb_valid      = memwb_q.valid;
    wb_reg_write  = memwb_q.valid & wb_bits[WB_REG_WRITE_B];
    wb_mem_to_reg = memwb_q.valid & wb_bits[WB_MEM_TO_REG_B];
  end

`ifdef CTRL_PIPE_STATS_EN
  // Counters only advance on edges where the pipe actually moves.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bubble_cnt <= '0;
      retire_cnt <= '0;
    end else if (!freeze) begin
      if (flush || hazard_stall) bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (memwb_q.valid)         retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed, table-driven bench for ctrl_pipe (stats checks under CTRL_PIPE_STATS_EN).
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [1:0] id_wb;
  logic [2:0] id_mem;
  logic [3:0] id_ex;
  logic       hazard_stall, flush, freeze;
  logic       ex_reg_dst, ex_alu_src;
  logic [1:0] ex_alu_op;
  logic       mem_branch, mem_read, mem_write;
  logic       wb_reg_write, wb_mem_to_reg;
  logic       ex_valid, mem_valid, wb_valid;
`ifdef CTRL_PIPE_STATS_EN
  logic [3:0] bubble_cnt, retire_cnt;
`endif

  always #5 clk = ~clk;

`ifdef CTRL_PIPE_STATS_EN
  ctrl_pipe #(.CNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_wb         (id_wb),
    .id_mem        (id_mem),
    .id_ex         (id_ex),
    .hazard_stall  (hazard_stall),
    .flush         (flush),
    .freeze        (freeze),
    .ex_reg_dst    (ex_reg_dst),
    .ex_alu_src    (ex_alu_src),
    .ex_alu_op     (ex_alu_op),
    .mem_branch    (mem_branch),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .ex_valid      (ex_valid),
    .mem_valid     (mem_valid),
    .wb_valid      (wb_valid),
    .bubble_cnt    (bubble_cnt),
    .retire_cnt    (retire_cnt)
  );
`else
  ctrl_pipe dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_wb         (id_wb),
    .id_mem        (id_mem),
    .id_ex         (id_ex),
    .hazard_stall  (hazard_stall),
    .flush         (flush),
    .freeze        (freeze),
    .ex_reg_dst    (ex_reg_dst),
    .ex_alu_src    (ex_alu_src),
    .ex_alu_op     (ex_alu_op),
    .mem_branch    (mem_branch),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .ex_valid      (ex_valid),
    .mem_valid     (mem_valid),
    .wb_valid      (wb_valid)
  );
`endif

  logic [11:0] outs;
  assign outs = {ex_valid, ex_reg_dst, ex_alu_op, ex_alu_src,
                 mem_valid, mem_branch, mem_read, mem_write,
                 wb_valid, wb_reg_write, wb_mem_to_reg};

  // Expected stage fields: EX {valid,reg_dst,alu_op,alu_src}, MEM {valid,b,r,w}, WB {valid,rw,m2r}
  localparam logic [4:0] EX_0  = 5'b00000, EX_R = 5'b11100, EX_LS = 5'b10001, EX_B = 5'b10010;
  localparam logic [3:0] MEM_0 = 4'b0000, MEM_R = 4'b1000, MEM_LW = 4'b1010,
                         MEM_SW = 4'b1001, MEM_B = 4'b1100;
  localparam logic [2:0] WB_0  = 3'b000, WB_R = 3'b110, WB_LW = 3'b111, WB_SW = 3'b100,
                         WB_B = 3'b100;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [8:0]  bundle;
    logic        stall;
    logic        flush;
    logic        freeze;
    logic [11:0] exp;
    int          bub;
    int          ret;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;
  logic [8:0] b_r, b_lw, b_sw, b_beq, b_0;

  task automatic add(input logic r, input logic v, input logic [8:0] b, input logic st,
                     input logic fl, input logic fz, input logic [11:0] e,
                     input int bu, input int re);
    vec_t x;
    x.rst = r; x.valid = v; x.bundle = b; x.stall = st; x.flush = fl; x.freeze = fz;
    x.exp = e; x.bub = bu; x.ret = re;
    vq.push_back(x);
  endtask

  task automatic drive(input logic r, input logic v, input logic [8:0] b, input logic st,
                       input logic fl, input logic fz);
    rst = r; id_valid = v; id_wb = b[8:7]; id_mem = b[6:4]; id_ex = b[3:0];
    hazard_stall = st; flush = fl; freeze = fz;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    b_r   = ctrl_decode(OP_R);
    b_lw  = ctrl_decode(OP_LW);
    b_sw  = ctrl_decode(OP_SW);
    b_beq = ctrl_decode(OP_BEQ);
    b_0   = '0;

    //  rst v  bundle st fl fz  expected {EX,MEM,WB}       bub ret
    add(0, 1, b_r,   0, 0, 0, {EX_0,  MEM_0,  WB_0},  0, 0);
    add(0, 1, b_r,   0, 0, 0, {EX_0,  MEM_0,  WB_0},  0, 0);
    add(1, 1, b_r,   0, 0, 0, {EX_R,  MEM_0,  WB_0},  0, 0);
    add(1, 0, b_r,   0, 0, 0, {EX_0,  MEM_R,  WB_0},  0, 0);
    add(1, 0, b_0,   0, 0, 0, {EX_0,  MEM_0,  WB_R},  0, 0);
    add(1, 1, b_lw,  0, 0, 0, {EX_LS, MEM_0,  WB_0},  0, 1);
    add(1, 1, b_sw,  0, 0, 0, {EX_LS, MEM_LW, WB_0},  0, 1);
    add(1, 0, b_0,   0, 0, 0, {EX_0,  MEM_SW, WB_LW}, 0, 1);
    add(1, 0, b_0,   0, 0, 0, {EX_0,  MEM_0,  WB_SW}, 0, 2);
    add(1, 0, b_0,   0, 0, 0, {EX_0,  MEM_0,  WB_0},  0, 3);
    add(1, 1, b_lw,  0, 0, 0, {EX_LS, MEM_0,  WB_0},  0, 3);
    add(1, 1, b_r,   1, 0, 0, {EX_0,  MEM_LW, WB_0},  1, 3);
    add(1, 1, b_r,   0, 0, 0, {EX_R,  MEM_0,  WB_LW}, 1, 3);
    add(1, 0, b_0,   0, 0, 0, {EX_0,  MEM_R,  WB_0},  1, 4);
    add(1, 0, b_0,   0, 0, 0, {EX_0,  MEM_0,  WB_R},  1, 4);
    add(1, 1, b_beq, 0, 0, 0, {EX_B,  MEM_0,  WB_0},  1, 5);
    add(1, 1, b_r,   0, 0, 0, {EX_R,  MEM_B,  WB_0},  1, 5);
    add(1, 1, b_sw,  0, 1, 0, {EX_0,  MEM_0,  WB_B},  2, 5);
    add(1, 0, b_0,   0, 0, 0, {EX_0,  MEM_0,  WB_0},  2, 6);
    add(1, 1, b_lw,  0, 0, 0, {EX_LS, MEM_0,  WB_0},  2, 6);
    add(1, 1, b_r,   0, 0, 0, {EX_R,  MEM_LW, WB_0},  2, 6);
    add(1, 1, b_sw,  1, 1, 1, {EX_R,  MEM_LW, WB_0},  2, 6);
    add(1, 1, b_sw,  1, 1, 1, {EX_R,  MEM_LW, WB_0},  2, 6);
    add(1, 1, b_sw,  1, 1, 1, {EX_R,  MEM_LW, WB_0},  2, 6);
    add(1, 1, b_sw,  1, 1, 0, {EX_0,  MEM_0,  WB_LW}, 3, 6);
    add(1, 0, b_0,   0, 0, 0, {EX_0,  MEM_0,  WB_0},  3, 7);
    add(1, 1, b_r,   0, 0, 0, {EX_R,  MEM_0,  WB_0},  3, 7);
    add(1, 1, b_lw,  0, 0, 0, {EX_LS, MEM_R,  WB_0},  3, 7);
    add(0, 1, b_sw,  0, 0, 1, {EX_0,  MEM_0,  WB_0},  0, 0);
    add(1, 0, b_0,   0, 0, 0, {EX_0,  MEM_0,  WB_0},  0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].valid, vq[i].bundle, vq[i].stall, vq[i].flush, vq[i].freeze);
      @(posedge clk);
      #1;
      check($sformatf("row%0d_outs", i), 32'(outs), 32'(vq[i].exp));
`ifdef CTRL_PIPE_STATS_EN
      check($sformatf("row%0d_bubble_cnt", i), 32'(bubble_cnt), 32'(4'(vq[i].bub)));
      check($sformatf("row%0d_retire_cnt", i), 32'(retire_cnt), 32'(4'(vq[i].ret)));
`endif
    end

    // Back-to-back R stream: full throughput, 17 retirements wrap a 4-bit counter to 1.
    for (int c = 1; c <= 20; c++) begin
      if (c <= 17) drive(1, 1, b_r, 0, 0, 0);
      else         drive(1, 0, b_0, 0, 0, 0);
      @(posedge clk);
      #1;
      check($sformatf("stream%0d_ex_valid", c), 32'(ex_valid), 32'(c <= 17));
      check($sformatf("stream%0d_wb_reg_write", c), 32'(wb_reg_write),
            32'(c >= 3 && c <= 19));
    end
`ifdef CTRL_PIPE_STATS_EN
    check("wrap_retire_cnt", 32'(retire_cnt), 32'd1);
    check("wrap_bubble_cnt", 32'(bubble_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
